hs_fifo_stage: RTL and testbench



---
 rtl/hs_fifo_stage_pkg.sv | 14 +
 rtl/hs_fifo_stage_if.sv | 35 +++
 rtl/hs_fifo_stage_mem.sv | 29 ++
 rtl/hs_fifo_stage.sv | 126 ++++++++++++
 tb/tb_hs_fifo_stage.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/hs_fifo_stage_pkg.sv
// Shared definitions for the handshake FIFO stage: default token width,
// token type and the pointer-width helper used by the stage and its memory.
package hs_pkg;

  localparam int DATA_WIDTH = 32;

  typedef logic [DATA_WIDTH-1:0] token_t;

  // Address width needed to index 'depth' entries; never narrower than 1 bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/hs_fifo_stage_if.sv
// Handshake bundle for one FIFO stage: the upstream consumer side
// (req_l/ack_l/din) and the downstream producer side (req_r/ack_r/dout).
// The slave modport is the FIFO's view; master is the environment's view.
interface hs_fifo_stage_if
  import hs_pkg::*;
#(
  parameter int DATA_WIDTH = hs_pkg::DATA_WIDTH
);

  logic                  req_l;
  logic                  ack_l;
  logic [DATA_WIDTH-1:0] din;
  logic                  req_r;
  logic                  ack_r;
  logic [DATA_WIDTH-1:0] dout;

  modport slave (
    output req_l,
    input  ack_l,
    input  din,
    input  req_r,
    output ack_r,
    output dout
  );

  modport master (
    input  req_l,
    output ack_l,
    output din,
    output req_r,
    input  ack_r,
    input  dout
  );

endinterface

// File: rtl/hs_fifo_stage_mem.sv
// Storage array for the FIFO stage: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module hs_fifo_mem
  import hs_pkg::*;
#(
  parameter  int DATA_WIDTH = hs_pkg::DATA_WIDTH,
  parameter  int DEPTH      = 4,
  localparam int PTR_W      = ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [PTR_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port: store the incoming token when enabled.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hs_fifo_stage.sv
// Elastic req/ack buffer for one dataflow edge. Upstream side acts as a
// consumer (registered req_l, 1-cycle ack_l with din); downstream side acts
// as a producer (level req_r, registered 1-cycle ack_r with dout).
// Optional macro HS_FIFO_PROTO_CHECK_EN enables the sticky protocol error
// flag 'err' and a simulation message per violation; otherwise err is 0.
// A push while full is dropped in both builds so the datapath is identical.
module hs_fifo_stage
  import hs_pkg::*;
#(
  parameter  int DATA_WIDTH = hs_pkg::DATA_WIDTH,
  parameter  int DEPTH      = 4,
  localparam int PTR_W      = ptr_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  hs_fifo_stage_if.slave       bus,
  output logic [PTR_W:0]       level,
  output logic [31:0]          count,
  output logic                 err
);

  localparam int             LVL_W   = PTR_W + 1;
  localparam logic [PTR_W:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [PTR_W:0] LVL_ONE = LVL_W'(1);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        level_q, level_d;
  logic                  req_l_q, req_l_d;
  logic                  ack_r_q, ack_r_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [31:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  full;
  logic                  push;
  logic                  pop;

  assign full = (level_q == DEPTH_L);
  assign push = bus.ack_l & ~full;
  // No back-to-back acks: a pop is only allowed when ack_r is currently low.
  assign pop  = bus.req_r & ~ack_r_q & (level_q != '0);

  hs_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push & ~rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.din),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // Next-state for pointers, occupancy and both handshake outputs.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (push ? PTR_W'(1) : '0);
    rd_ptr_d = rd_ptr_q + (pop  ? PTR_W'(1) : '0);
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    // req_l drops for at least one cycle after every ack_l, and while full.
    req_l_d = ~bus.ack_l & (level_d < DEPTH_L);
    ack_r_d = pop;
    dout_d  = pop ? rd_data : dout_q;
    count_d = count_q + (pop ? 32'd1 : 32'd0);
  end

  // State registers; reset discards buffered tokens and ignores a coincident ack_l.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      req_l_q  <= 1'b0;
      ack_r_q  <= 1'b0;
      dout_q   <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      req_l_q  <= req_l_d;
      ack_r_q  <= ack_r_d;
      dout_q   <= dout_d;
      count_q  <= count_d;
    end
  end

  assign bus.req_l = req_l_q;
  assign bus.ack_r = ack_r_q;
  assign bus.dout  = dout_q;
  assign level     = level_q;
  assign count     = count_q;

`ifdef HS_FIFO_PROTO_CHECK_EN
  logic        err_q;
  logic [31:0] cyc_q;
  logic        viol;

  // An ack without an outstanding request, or into a full buffer, is a violation.
  assign viol = bus.ack_l & (~req_l_q | full);

  // Sticky error flag plus a cycle counter used to timestamp violations.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (viol) begin
        err_q <= 1'b1;
        $display("hs_fifo_stage: protocol violation at cycle %0d", cyc_q);
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hs_fifo_stage.sv
// Scoreboard bench for hs_fifo_stage: accepted tokens are queued at the
// edge they are pushed, and a negedge monitor pops and compares on each
// ack_r while checking occupancy, delivery count and handshake rules.
module tb_hs_fifo_stage;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  level;
  logic [31:0] count;
  logic        err;

  hs_fifo_stage_if #(.DATA_WIDTH(DW)) bus();

  hs_fifo_stage #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .level (level),
    .count (count),
    .err   (err)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_q [$];
  int          delivered   = 0;
  bit          started     = 0;
  bit          s_rst;
  bit          s_ack_l;
  bit          exp_ack_r;
  bit          exp_err     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model update at each active edge, using pre-edge values.
  always @(posedge clk) begin
    s_rst     = rst;
    s_ack_l   = bus.ack_l;
    exp_ack_r = !rst && bus.req_r && !bus.ack_r && (exp_q.size() != 0);
    if (rst) begin
      exp_q.delete();
      delivered = 0;
      exp_err   = 0;
    end else begin
`ifdef HS_FIFO_PROTO_CHECK_EN
      if (bus.ack_l && (!bus.req_l || exp_q.size() == DEPTH)) exp_err = 1;
`endif
      if (bus.ack_l && exp_q.size() < DEPTH) exp_q.push_back(bus.din);
    end
    started = 1;
  end

  // Monitor: compares everything the DUT presents after each edge.
  always @(negedge clk) begin
    if (started) begin
      if (s_rst) begin
        check("rst_ack_r", 32'(bus.ack_r), 32'd0);
        check("rst_dout", bus.dout, 32'd0);
      end else begin
        check("ack_r_rule", 32'(bus.ack_r), 32'(exp_ack_r));
      end
      if (bus.ack_r) begin
        if (exp_q.size() == 0) begin
          check("unexpected_token", bus.dout, 32'hxxxxxxxx);
        end else begin
          delivered++;
          check("dout", bus.dout, exp_q.pop_front());
        end
      end
      check("level", 32'(level), 32'(exp_q.size()));
      check("count", count, 32'(delivered));
      check("req_l", 32'(bus.req_l),
            32'(!s_rst && !s_ack_l && (exp_q.size() < DEPTH)));
      check("err", 32'(err), 32'(exp_err));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one token as soon as the stage requests it (bounded wait).
  task automatic send(input logic [31:0] v);
    int n = 0;
    while (!bus.req_l && n < 20) begin
      idle(1);
      n++;
    end
    if (!bus.req_l) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: req_l stayed %0d, required 1", bus.req_l);
    end else begin
      bus.ack_l = 1'b1;
      bus.din   = v;
      idle(1);
      bus.ack_l = 1'b0;
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.ack_l = 1'b0;
    bus.din   = '0;
    bus.req_r = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(3);

    // Single token through an idle stage.
    bus.req_r = 1'b1;
    send(32'h5);
    idle(4);

    // Fill to DEPTH with downstream stalled, then drain in order.
    bus.req_r = 1'b0;
    for (int i = 10; i < 14; i++) send(32'(i));
    idle(3);
    bus.req_r = 1'b1;
    idle(12);

    // Stream 20 tokens with downstream always requesting (pointer wrap).
    for (int i = 0; i < 20; i++) send(32'(100 + i));
    idle(10);

    // Ack while req_l is low and the buffer is full: write must be dropped.
    bus.req_r = 1'b0;
    for (int i = 0; i < 4; i++) send(32'(200 + i));
    idle(2);
    bus.ack_l = 1'b1;
    bus.din   = 32'hDEAD;
    idle(1);
    bus.ack_l = 1'b0;
    idle(2);
    bus.req_r = 1'b1;
    idle(12);

    // Randomized traffic on both sides.
    for (int c = 0; c < 3000; c++) begin
      bus.req_r = ($urandom_range(0, 3) != 0);
      if (bus.req_l && $urandom_range(0, 9) < 6) begin
        bus.ack_l = 1'b1;
        bus.din   = $urandom;
      end else begin
        bus.ack_l = 1'b0;
      end
      idle(1);
    end
    bus.ack_l = 1'b0;

    // Mid-stream reset with three tokens buffered.
    bus.req_r = 1'b1;
    idle(12);
    bus.req_r = 1'b0;
    for (int i = 0; i < 3; i++) send(32'(300 + i));
    rst       = 1'b1;
    bus.ack_l = 1'b1;
    bus.din   = 32'hBAD0;
    idle(1);
    bus.ack_l = 1'b0;
    rst       = 1'b0;
    idle(1);
    send(32'h77);
    bus.req_r = 1'b1;
    idle(12);

    check("drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
